// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, screen bounds and colour type for the
// sync generator and the graphics blocks that consume its pixel coordinates.
package vga_pkg;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;

  typedef logic [11:0] rgb_t;

endpackage

// File: rtl/vga_sync_gen_mod_m_tick.sv
// Generic divide-by-M counter: counts 0..M-1 and emits a registered one-clk
// tick on the clock after the count reaches M-1.
module mod_m_tick #(
  parameter int M = 4
) (
  input  logic clk,
  input  logic reset,
  output logic o_max,
  output logic o_tick
);

  localparam int            W        = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0]  CNT_LAST = W'(M - 1);

  logic [W-1:0] r_cnt;
  logic         r_tick;
  logic         w_max;

  assign w_max  = (r_cnt == CNT_LAST);
  assign o_max  = w_max;
  assign o_tick = r_tick;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_max;
      r_cnt  <= w_max ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, line/frame ticks and a
// one-pixel output stage that keeps rgb, hsync and vsync on the same pixel.
module vga_sync_gen #(
  parameter int   CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int   H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int   H_FP      = vga_pkg::H_FP,
  parameter int   H_SYNC    = vga_pkg::H_SYNC,
  parameter int   H_BP      = vga_pkg::H_BP,
  parameter int   V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int   V_FP      = vga_pkg::V_FP,
  parameter int   V_SYNC    = vga_pkg::V_SYNC,
  parameter int   V_BP      = vga_pkg::V_BP,
  parameter logic SYNC_ACT  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  vga_pkg::rgb_t rgb_in,
  output logic          p_tick,
  output logic [9:0]    pix_x,
  output logic [9:0]    pix_y,
  output logic          video_on,
  output logic          line_tick,
  output logic          frame_tick,
  output logic          hsync,
  output logic          vsync,
  output vga_pkg::rgb_t rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic          w_tick;
  logic          w_div_max;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_line_tick;
  logic          r_frame_tick;
  logic          r_hsync;
  logic          r_vsync;
  vga_pkg::rgb_t r_rgb;
  logic          w_x_end;
  logic          w_y_end;
  logic          w_video_on;
  logic          w_hs_act;
  logic          w_vs_act;

  mod_m_tick #(.M(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .reset  (reset),
    .o_max  (w_div_max),
    .o_tick (w_tick)
  );

  assign w_x_end    = (r_x == X_LAST);
  assign w_y_end    = (r_y == Y_LAST);
  assign w_video_on = (r_x < X_VIS) && (r_y < Y_VIS);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can leave a value held and infer a latch.
  always_comb begin
    w_hs_act = 1'b0;
    w_vs_act = 1'b0;
    if ((r_x >= HS_BEG) && (r_x <= HS_END)) w_hs_act = 1'b1;
    if ((r_y >= VS_BEG) && (r_y <= VS_END)) w_vs_act = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_tick) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  // Ticks are registered one clk ahead so they coincide with the wrapping p_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_line_tick  <= w_div_max && w_x_end;
      r_frame_tick <= w_div_max && w_x_end && w_y_end;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hsync <= ~SYNC_ACT;
      r_vsync <= ~SYNC_ACT;
    end else if (w_tick) begin
      r_rgb   <= w_video_on ? rgb_in : 12'h000;
      r_hsync <= w_hs_act ? SYNC_ACT : ~SYNC_ACT;
      r_vsync <= w_vs_act ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign p_tick     = w_tick;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign video_on   = w_video_on;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign rgb        = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, a shrunken
// instance so whole frames fit in a short run; both against a clock-count model.
module tb_vga_sync_gen;
  import vga_pkg::*;

  typedef struct {
    int m, hd, hfp, hs, hbp, vd, vfp, vs, vbp;
  } tim_t;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       lt;
    logic       ft;
    logic       hs;
    logic       vs;
    rgb_t       rgb;
  } obs_t;

  typedef struct {
    int   x;
    int   y;
    rgb_t rin;
    logic von;
    rgb_t rgb;
  } blank_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rgb_t rgb_in_b = '0, rgb_in_s = '0;
  logic pt_b, von_b, lt_b, ft_b, hs_b, vs_b;
  logic pt_s, von_s, lt_s, ft_s, hs_s, vs_s;
  logic [9:0] x_b, y_b, x_s, y_s;
  rgb_t rgb_b, rgb_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_b), .p_tick(pt_b),
    .pix_x(x_b), .pix_y(y_b), .video_on(von_b), .line_tick(lt_b),
    .frame_tick(ft_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .H_DISPLAY(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_DISPLAY(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACT(1'b0)
  ) u_sml (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_s), .p_tick(pt_s),
    .pix_x(x_s), .pix_y(y_s), .video_on(von_s), .line_tick(lt_s),
    .frame_tick(ft_s), .hsync(hs_s), .vsync(vs_s), .rgb(rgb_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, wanted event", name);
  endtask

  // Expected outputs k clocks after reset release, from pixel-slot arithmetic.
  function automatic obs_t model(input tim_t t, input int k, input rgb_t hold);
    int ht, vt, adv, pos, prev, px, py;
    obs_t o;
    ht  = t.hd + t.hfp + t.hs + t.hbp;
    vt  = t.vd + t.vfp + t.vs + t.vbp;
    adv = (k == 0) ? 0 : (k - 1) / t.m;
    pos = adv % (ht * vt);
    o.x      = 10'(pos % ht);
    o.y      = 10'(pos / ht);
    o.p_tick = (k >= t.m) && (k % t.m == 0);
    o.von    = (pos % ht < t.hd) && (pos / ht < t.vd);
    o.lt     = o.p_tick && (pos % ht == ht - 1);
    o.ft     = o.lt && (pos / ht == vt - 1);
    if (adv == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.rgb = '0;
    end else begin
      prev = (pos + ht * vt - 1) % (ht * vt);
      px = prev % ht;
      py = prev / ht;
      o.hs  = !((px >= t.hd + t.hfp) && (px < t.hd + t.hfp + t.hs));
      o.vs  = !((py >= t.vd + t.vfp) && (py < t.vd + t.vfp + t.vs));
      o.rgb = hold;
    end
    return o;
  endfunction

  initial begin
    tim_t t_big, t_sml;
    obs_t act, exp_b, exp_s;
    rgb_t hold_b, hold_s;
    blank_vec_t tbl[6];
    int n, clks, hs_low, first_x, vs_low, refresh, max_y, lines;
    bit found;

    t_big = '{CLK_DIV, H_DISPLAY, H_FP, H_SYNC, H_BP, V_DISPLAY, V_FP, V_SYNC, V_BP};
    t_sml = '{4, 16, 2, 4, 3, 8, 2, 2, 3};
    tbl[0] = '{15, 7, 12'hff0, 1'b1, 12'hff0};
    tbl[1] = '{16, 0, 12'hff0, 1'b0, 12'h000};
    tbl[2] = '{0, 8, 12'hff0, 1'b0, 12'h000};
    tbl[3] = '{24, 14, 12'hff0, 1'b0, 12'h000};
    tbl[4] = '{0, 0, 12'h5a3, 1'b1, 12'h5a3};
    tbl[5] = '{15, 0, 12'h0c7, 1'b1, 12'h0c7};

    // Random colour stream, every clock compared against the model.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    hold_b = '0;
    hold_s = '0;
    for (int k = 0; k < 10000; k++) begin
      act   = {pt_b, x_b, y_b, von_b, lt_b, ft_b, hs_b, vs_b, rgb_b};
      exp_b = model(t_big, k, hold_b);
      check($sformatf("big_k%0d", k), 64'(act), 64'(exp_b));
      act   = {pt_s, x_s, y_s, von_s, lt_s, ft_s, hs_s, vs_s, rgb_s};
      exp_s = model(t_sml, k, hold_s);
      check($sformatf("sml_k%0d", k), 64'(act), 64'(exp_s));
      rgb_in_b = rgb_t'($urandom);
      rgb_in_s = rgb_t'($urandom);
      if (exp_b.p_tick) hold_b = exp_b.von ? rgb_in_b : 12'h000;
      if (exp_s.p_tick) hold_s = exp_s.von ? rgb_in_s : 12'h000;
      @(negedge clk);
    end

    // One full-size line with rgb_in = pix_x: period, hsync width/position, alignment.
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      rgb_in_b = {2'b00, x_b};
      if (lt_b) found = 1;
    end
    if (!found) timeout("line_tick_start");
    clks = 0; hs_low = 0; first_x = -1; found = 0;
    while (!found && clks < 4000) begin
      @(negedge clk);
      rgb_in_b = {2'b00, x_b};
      clks++;
      if (pt_b && !hs_b) begin
        if (first_x < 0) begin
          first_x = int'(x_b);
          check("hsync_edge_rgb", 64'(rgb_b), 64'(0));
        end
        hs_low++;
      end
      if (pt_b && x_b >= 10'd1 && x_b <= 10'd640 && y_b < 10'd480)
        check($sformatf("align_x%0d", x_b), 64'(rgb_b), 64'(x_b - 10'd1));
      if (pt_b && x_b == 10'd641)
        check("blank_x640", 64'(rgb_b), 64'(0));
      if (lt_b) found = 1;
    end
    if (!found) timeout("line_tick_end");
    check("line_period_clks", 64'(clks), 64'(3200));
    check("hsync_low_pixels", 64'(hs_low), 64'(96));
    check("hsync_first_low_x", 64'(first_x), 64'(657));

    // Reset asserted mid-line.
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (x_b == 10'd300) found = 1;
    end
    if (!found) timeout("reach_x300");
    reset = 1'b1;
    #1;
    check("rst_pix_x", 64'(x_b), 64'(0));
    check("rst_pix_y", 64'(y_b), 64'(0));
    check("rst_rgb", 64'(rgb_b), 64'(0));
    check("rst_hsync_vsync", 64'({hs_b, vs_b}), 64'(2'b11));
    check("rst_ticks", 64'({pt_b, lt_b, ft_b}), 64'(0));
    check("rst_video_on", 64'(von_b), 64'(1));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0; found = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (pt_b) found = 1;
    end
    check("first_ptick_clks", 64'(n), 64'(4));

    // One full small frame: period, vsync width, refresh point, y bound.
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (ft_s) found = 1;
    end
    if (!found) timeout("frame_tick_start");
    clks = 0; vs_low = 0; refresh = 0; max_y = 0; lines = 0; found = 0;
    while (!found && clks < 3000) begin
      @(negedge clk);
      clks++;
      if (int'(y_s) > max_y) max_y = int'(y_s);
      if (pt_s && !vs_s) vs_low++;
      if (pt_s && y_s == 10'd9 && x_s == 10'd0) refresh++;
      if (lt_s) lines++;
      if (ft_s) found = 1;
    end
    if (!found) timeout("frame_tick_end");
    check("frame_period_clks", 64'(clks), 64'(1500));
    check("vsync_low_pixels", 64'(vs_low), 64'(50));
    check("refresh_once", 64'(refresh), 64'(1));
    check("max_pix_y", 64'(max_y), 64'(14));
    check("lines_per_frame", 64'(lines), 64'(15));

    // Blanking corners on the small instance.
    for (int i = 0; i < 6; i++) begin
      rgb_in_s = tbl[i].rin;
      found = 0;
      for (int c = 0; c < 3000 && !found; c++) begin
        @(negedge clk);
        if (pt_s && int'(x_s) == tbl[i].x && int'(y_s) == tbl[i].y) found = 1;
      end
      if (!found) begin
        timeout($sformatf("blank_reach_%0d_%0d", tbl[i].x, tbl[i].y));
      end else begin
        check($sformatf("video_on_%0d_%0d", tbl[i].x, tbl[i].y), 64'(von_s), 64'(tbl[i].von));
        @(posedge clk);
        #1;
        check($sformatf("rgb_%0d_%0d", tbl[i].x, tbl[i].y), 64'(rgb_s), 64'(tbl[i].rgb));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Generates 640x480@60 Hz VGA timing from the system clock and drives `pix_x`/`pix_y` to the graphics blocks (paddle, ball, bricks). It takes their 12-bit colour back on `rgb_in`. It registers that colour with blanking and outputs it, together with `hsync`/`vsync` aligned to the same pixel, to the board VGA connector. It is the producer side of the pixel-coordinate/colour interface the graphics blocks consume.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz); must be ≥2.
- H_DISPLAY, 640: visible pixels per line.
- H_FP, 16: horizontal front porch (right border).
- H_SYNC, 96: horizontal retrace width.
- H_BP, 48: horizontal back porch (left border).
- V_DISPLAY, 480: visible lines.
- V_FP, 10: vertical front porch (bottom border).
- V_SYNC, 2: vertical retrace lines.
- V_BP, 33: vertical back porch (top border).
- SYNC_ACT, 0: active level of `hsync`/`vsync` (0 = active-low).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rgb_in` in 12: colour for the current (`pix_x`, `pix_y`) from the graphics mux.
- `p_tick` out 1: one-clk pixel-enable pulse.
- `pix_x` out 10: horizontal counter, 0..H_TOTAL-1.
- `pix_y` out 10: vertical counter, 0..V_TOTAL-1.
- `video_on` out 1: high when (`pix_x`, `pix_y`) is in the visible area.
- `line_tick` out 1: one-clk pulse on the p_tick that wraps `pix_x` to 0.
- `frame_tick` out 1: one-clk pulse on the p_tick that wraps both counters to (0,0).
- `hsync` out 1: horizontal sync to the connector, pipeline-aligned with `rgb`.
- `vsync` out 1: vertical sync to the connector, pipeline-aligned with `rgb`.
- `rgb` out 12: registered, blanked colour to the connector.

Behaviour:
- One clock; reset is asynchronous and active-high, ports named `clk` and `reset`.
- Derived values: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
- Reset values: divider=0, `pix_x`=0, `pix_y`=0, `p_tick`=0, `line_tick`=0, `frame_tick`=0, `rgb`=0, `hsync`=`vsync`=~SYNC_ACT (inactive). `video_on` follows the counters, so it is 1 in reset.
- Divider:
  - counts 0..CLK_DIV-1 and wraps to 0.
  - `p_tick` is registered: high for exactly one clk, on the clk after the divider reaches CLK_DIV-1. First `p_tick` is CLK_DIV clks after reset release.
- Counters advance only on clocks where `p_tick`=1:
  - `pix_x` increments; at H_TOTAL-1 it wraps to 0 and `pix_y` increments.
  - `pix_y` wraps from V_TOTAL-1 to 0 only when `pix_x` wraps at the same time.
  - `pix_x` and `pix_y` are driven directly from the counter registers, with no combinational path from `rgb_in`.
- `line_tick`/`frame_tick`: registered, high on the same clk as the `p_tick` that performs the wrap. Never high when `p_tick`=0.
- Raw sync, combinational from the counters:
  - hsync_raw is active for `pix_x` in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656,751].
  - vsync_raw is active for `pix_y` in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] = [490,491].
- `video_on` = (`pix_x` < H_DISPLAY) && (`pix_y` < V_DISPLAY), combinational.
- Output stage: one pixel of latency, loaded only when `p_tick`=1, from the values present before the counters advance.
  - `rgb` <= `video_on` ? `rgb_in` : 12'h000.
  - `hsync` <= hsync_raw level.
  - `vsync` <= vsync_raw level.
  - `rgb`, `hsync` and `vsync` therefore always describe the same pixel and hold steady between p_ticks.
- Graphics blocks must present `rgb_in` combinationally valid before the next `p_tick` edge after `pix_x`/`pix_y` change (at least CLK_DIV-1 clks of settling).
- Reset asserted mid-frame: all registers return to their reset values immediately (asynchronous). Timing restarts from (0,0) with no partial-line artefact beyond the reset window.
- Graphics blocks' refresh point (`pix_y`=481, `pix_x`=0) occurs exactly once per frame.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_/V_ values and the derived totals);
  - the MAX_X=640 and MAX_Y=480 screen bounds already used by the graphics blocks;
  - a 12-bit rgb_t typedef.
- One natural sub-module, mod_m_tick: a generic divide-by-M counter with a registered one-clk tick. It is instantiated for the pixel divider. The h/v counters stay inline.

Test Plan:
- Reset: assert `reset` mid-line at `pix_x`=300 → the same clk edge gives `pix_x`=0, `pix_y`=0, `rgb`=0, `hsync`=`vsync`=1, `p_tick`=0. First `p_tick` comes 4 clks after release.
- Pixel rate: free-run 40 clks → `p_tick` pulses exactly every 4 clks, each 1 clk wide; `pix_x` steps 0→1→…→9.
- Horizontal timing, one line:
  - `hsync` is low for exactly 96 p_ticks, its first low pixel being `pix_x`=656, visible one p_tick later at the output.
  - `line_tick` pulses once, when `pix_x` goes 799→0.
  - Line period is 3200 clks.
- Frame timing:
  - `vsync` is low for 2 lines (`pix_y` 490–491, delayed one pixel).
  - `frame_tick` pulses once per 420000 p_ticks (1,680,000 clks), when (799,524)→(0,0).
  - `pix_y` never exceeds 524.
- Blanking: drive `rgb_in`=12'hff0 constantly.
  - `rgb`=12'hff0 for pixel (639,479), one p_tick later.
  - `rgb`=12'h000 for (640,0), (0,480) and (799,524).
  - `video_on` flips at exactly those coordinates.
- Alignment: drive `rgb_in`=`pix_x`[9:0] zero-extended → `rgb` always equals the previous p_tick's `pix_x` during visible area, and the `hsync` edge coincides with the `rgb` output sample for `pix_x`=656.
